// File: rtl/delay_calib_ctrl.sv
// Calibration controller for the DDCB cascade delay line: sweeps the enabled stage count
// upward and locks on the first code where the synchronised phase detector reports "late".
module delay_calib_ctrl #(
  parameter int NMBR_CASCADES = 6,
  parameter int SETTLE_CYCLES = 4,
  parameter int SAMPLE_CNT    = 8,
  localparam int CW = $clog2(NMBR_CASCADES + 1)
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     start,
  input  logic                     pd_late,
  input  logic                     man_en,
  input  logic [CW-1:0]            man_code,
  output logic [NMBR_CASCADES-1:0] select,
  output logic [CW-1:0]            code,
  output logic                     busy,
  output logic                     done,
  output logic                     fail
);

  localparam int STEP_MAX = (SETTLE_CYCLES > SAMPLE_CNT) ? SETTLE_CYCLES : SAMPLE_CNT;
  localparam int SW = $clog2(STEP_MAX + 1);
  localparam int LW = $clog2(SAMPLE_CNT + 1);

  localparam logic [SW-1:0] SETTLE_LAST = SW'(SETTLE_CYCLES - 1);
  localparam logic [SW-1:0] SAMPLE_LAST = SW'(SAMPLE_CNT - 1);
  localparam logic [LW-1:0] LATE_HALF   = LW'(SAMPLE_CNT / 2);
  localparam logic [CW-1:0] CODE_MAX    = CW'(NMBR_CASCADES);

  typedef enum logic [2:0] {
    IDLE,
    APPLY,
    SETTLE,
    SAMPLE,
    DECIDE,
    DONE,
    FAIL
  } state_t;

  state_t state, next_state;

  logic                     pd_sync1, pd_sync2;
  logic [SW-1:0]            step_cnt;
  logic [LW-1:0]            late_cnt;
  logic [NMBR_CASCADES-1:0] therm;
  logic [CW-1:0]            man_sat;
  logic                     settle_last, sample_last, is_late, at_max, idle_like;

  assign settle_last = (step_cnt == SETTLE_LAST);
  assign sample_last = (step_cnt == SAMPLE_LAST);
  assign is_late     = (late_cnt > LATE_HALF);
  assign at_max      = (code == CODE_MAX);
  assign man_sat     = (man_code > CODE_MAX) ? CODE_MAX : man_code;
  assign idle_like   = (state == IDLE) || (state == DONE) || (state == FAIL);

  // Thermometer decode: exactly `code` LSBs enabled.
  always_comb begin
    therm = '0;
    for (int i = 0; i < NMBR_CASCADES; i++) begin
      therm[i] = (CW'(i) < code);
    end
  end

  always_comb begin
    next_state = state;
    if (man_en) begin
      next_state = IDLE;
    end else begin
      case (state)
        IDLE, DONE, FAIL: if (start) next_state = APPLY;
        APPLY:            next_state = SETTLE;
        SETTLE:           if (settle_last) next_state = SAMPLE;
        SAMPLE:           if (sample_last) next_state = DECIDE;
        DECIDE: begin
          if (is_late)     next_state = DONE;
          else if (at_max) next_state = FAIL;
          else             next_state = APPLY;
        end
        default:          next_state = IDLE;
      endcase
    end
  end

  // Manual override wins over any calibration activity.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      pd_sync1 <= 1'b0;
      pd_sync2 <= 1'b0;
      select   <= '0;
      code     <= '0;
      busy     <= 1'b0;
      done     <= 1'b0;
      fail     <= 1'b0;
      step_cnt <= '0;
      late_cnt <= '0;
    end else begin
      state    <= next_state;
      pd_sync1 <= pd_late;
      pd_sync2 <= pd_sync1;
      select   <= therm;
      if (man_en) begin
        code     <= man_sat;
        busy     <= 1'b0;
        done     <= 1'b0;
        fail     <= 1'b0;
        step_cnt <= '0;
        late_cnt <= '0;
      end else begin
        case (state)
          APPLY:  step_cnt <= '0;
          SETTLE: step_cnt <= settle_last ? '0 : step_cnt + SW'(1);
          SAMPLE: begin
            step_cnt <= sample_last ? '0 : step_cnt + SW'(1);
            late_cnt <= late_cnt + LW'(pd_sync2);
          end
          DECIDE: begin
            if (is_late) begin
              done <= 1'b1;
              busy <= 1'b0;
            end else if (at_max) begin
              fail <= 1'b1;
              busy <= 1'b0;
            end else begin
              code     <= code + CW'(1);
              late_cnt <= '0;
            end
          end
          default: begin
            if (idle_like && start) begin
              code     <= '0;
              done     <= 1'b0;
              fail     <= 1'b0;
              busy     <= 1'b1;
              step_cnt <= '0;
              late_cnt <= '0;
            end
          end
        endcase
      end
    end
  end

endmodule
